// File: rtl/bundler_readout.sv
// Streams a bundler counter array out one chunk per valid/ready beat, holding the bundler while busy.
// Define BUNDLER_READOUT_CLR_EN to emit a bundler clear pulse when a readout completes.
module bundler_readout #(
    parameter int HVDimension   = 512,
    parameter int CounterWidth  = 8,
    parameter int ChunkCounters = 8,
    localparam int NumChunks    = HVDimension / ChunkCounters,
    localparam int IdxW         = $clog2(NumChunks),
    localparam int ChunkW       = ChunkCounters * CounterWidth
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic signed [HVDimension-1:0][CounterWidth-1:0] counter_i,
    input  logic                                       start_i,
    input  logic                                       abort_i,
    output logic                                       busy_o,
    output logic [ChunkW-1:0]                          data_o,
    output logic                                       valid_o,
    input  logic                                       ready_i,
    output logic [IdxW-1:0]                            idx_o,
    output logic                                       last_o,
    output logic                                       done_o,
    output logic                                       clr_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

    state_t            state_reg, state_next;
    logic [ChunkW-1:0] data_reg;
    logic [IdxW-1:0]   idx_reg;
    logic              last_reg;
    logic              load;
    logic [IdxW-1:0]   load_idx;

    // A packed slice of counter_i already has counter j of the chunk at bit j*CounterWidth.
    logic [ChunkW-1:0] chunk_arr [NumChunks];

    genvar gi;
    generate
        for (gi = 0; gi < NumChunks; gi++) begin : g_chunk
            assign chunk_arr[gi] = counter_i[gi*ChunkCounters +: ChunkCounters];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        load_idx   = '0;
        unique case (state_reg)
            IDLE: begin
                if (start_i && !abort_i) begin
                    load       = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                // Abort wins over a same-cycle handshake, so that beat is dropped.
                if (abort_i) begin
                    state_next = IDLE;
                end else if (ready_i) begin
                    if (idx_reg == LastIdx) begin
                        state_next = DONE;
                    end else begin
                        load     = 1'b1;
                        load_idx = idx_reg + 1'b1;
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            idx_reg   <= '0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                data_reg <= chunk_arr[load_idx];
                idx_reg  <= load_idx;
                last_reg <= (load_idx == LastIdx);
            end
        end
    end

    assign busy_o  = (state_reg != IDLE);
    assign valid_o = (state_reg == STREAM);
    assign done_o  = (state_reg == DONE);
    assign data_o  = data_reg;
    assign idx_o   = idx_reg;
    assign last_o  = last_reg;

`ifdef BUNDLER_READOUT_CLR_EN
    assign clr_o = (state_reg == DONE);
`else
    assign clr_o = 1'b0;
`endif

endmodule

// File: tb/tb_bundler_readout.sv
// Randomized self-checking bench for bundler_readout (16 counters, 4 per beat, 4 chunks).
module tb_bundler_readout;

    localparam int HV = 16;
    localparam int CW = 8;
    localparam int CC = 4;
    localparam int NC = HV / CC;

`ifdef BUNDLER_READOUT_CLR_EN
    localparam bit ClrEn = 1'b1;
`else
    localparam bit ClrEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic ready = 1'b0;
    logic signed [HV-1:0][CW-1:0] counter_bus;
    logic [CC*CW-1:0] data;
    logic busy, valid, last, done, clr;
    logic [1:0] idx;

    logic [CW-1:0] cnt [HV];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < HV; i++) counter_bus[i] = cnt[i];
    end

    bundler_readout #(
        .HVDimension(HV),
        .CounterWidth(CW),
        .ChunkCounters(CC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .counter_i(counter_bus),
        .start_i(start),
        .abort_i(abort),
        .busy_o(busy),
        .data_o(data),
        .valid_o(valid),
        .ready_i(ready),
        .idx_o(idx),
        .last_o(last),
        .done_o(done),
        .clr_o(clr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beat k: counters k*CC .. k*CC+CC-1, lowest counter in the lowest byte.
    function automatic logic [CC*CW-1:0] exp_chunk(input int k);
        logic [CC*CW-1:0] r;
        r = '0;
        for (int j = 0; j < CC; j++) r[j*CW +: CW] = cnt[k*CC + j];
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < HV; i++) cnt[i] = CW'($urandom);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_valid"}, 64'(valid), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_clr"}, 64'(clr), 64'd0);
    endtask

    // Drain beats first_k..NC-1; ready_mode 0 = always, 1 = random, 2 = pattern 1,0,0,1...
    task automatic drain(input string tag, input int first_k, input int ready_mode);
        int k;
        int cyc;
        k = first_k;
        cyc = 0;
        while (k < NC && cyc < 200) begin
            check({tag, "_valid"}, 64'(valid), 64'd1);
            check({tag, "_busy"}, 64'(busy), 64'd1);
            check({tag, "_idx"}, 64'(idx), 64'(k));
            check({tag, "_data"}, 64'(data), 64'(exp_chunk(k)));
            check({tag, "_last"}, 64'(last), 64'(k == NC - 1));
            check({tag, "_done_early"}, 64'(done), 64'd0);
            case (ready_mode)
                0: ready = 1'b1;
                1: ready = 1'($urandom_range(0, 1));
                default: ready = (cyc % 3 == 0);
            endcase
            if (ready) $display("%s beat idx=%0d data=%h", tag, idx, data);
            tick();
            if (ready) k++;
            cyc++;
        end
        check({tag, "_beats_in_budget"}, 64'(k), 64'(NC));
        ready = 1'b0;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_clr"}, 64'(clr), 64'(ClrEn));
        check({tag, "_done_valid"}, 64'(valid), 64'd0);
        check({tag, "_done_busy"}, 64'(busy), 64'd1);
        tick();
        check({tag, "_after_busy"}, 64'(busy), 64'd0);
        check({tag, "_after_done"}, 64'(done), 64'd0);
        check({tag, "_after_clr"}, 64'(clr), 64'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < HV; i++) cnt[i] = CW'(i - 8);
        rst = 1'b1;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        check("rst_idx", 64'(idx), 64'd0);
        check("rst_last", 64'(last), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_clr", 64'(clr), 64'd0);
        rst = 1'b0;
        tick();

        // Directed ramp, back-to-back beats.
        do_start();
        check("ramp_beat0_const", 64'(data), 64'hFBFA_F9F8);
        drain("ramp", 0, 0);

        // Same counters, stalled consumer.
        do_start();
        drain("stall", 0, 2);

        // Abort while starting ignored in IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("idle_abort");

        // Randomized counters and ready.
        for (int r = 0; r < 6; r++) begin
            fill_random();
            do_start();
            drain("rand", 0, 1);
        end

        // Abort on the handshake of chunk 2.
        fill_random();
        do_start();
        ready = 1'b1;
        tick();
        tick();
        check("abort_idx2", 64'(idx), 64'd2);
        check("abort_valid2", 64'(valid), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ready = 1'b0;
        check_idle("abort");
        tick();
        check_idle("abort_later");
        do_start();
        check("abort_restart_idx", 64'(idx), 64'd0);
        drain("abort_restart", 0, 0);

        // Asynchronous reset mid-stream at idx 1.
        fill_random();
        do_start();
        ready = 1'b1;
        tick();
        check("mrst_idx1", 64'(idx), 64'd1);
        rst = 1'b1;
        #1;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_valid", 64'(valid), 64'd0);
        check("mrst_data", 64'(data), 64'd0);
        check("mrst_idx", 64'(idx), 64'd0);
        check("mrst_last", 64'(last), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_clr", 64'(clr), 64'd0);
        #1;
        rst = 1'b0;
        ready = 1'b0;
        tick();
        do_start();
        drain("post_rst", 0, 0);

        // start held through a readout: one readout, next only from IDLE.
        fill_random();
        start = 1'b1;
        tick();
        drain("hold", 0, 0);
        tick();
        check("hold_second_valid", 64'(valid), 64'd1);
        check("hold_second_idx", 64'(idx), 64'd0);
        start = 1'b0;
        drain("hold2", 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bundler_readout.md
# bundler_readout

Drains the signed counter array of a bundler set over a narrow valid/ready stream, one chunk of counters per beat, so accumulated hypervector counts can be exported to memory or the host. It sits downstream of the bundler set: it is the reader for the counters the bundler writes. While busy, it asserts a hold that upstream logic uses to stall bundling. It can optionally issue the bundler clear once the last beat is accepted.

## Interface
- `HVDimension`, default 512: number of counters. Must be a multiple of `ChunkCounters`.
- `CounterWidth`, default 8: width of each signed counter.
- `ChunkCounters`, default 8: counters per output beat. `NumChunks = HVDimension/ChunkCounters`.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `counter_i` input `[HVDimension-1:0][CounterWidth-1:0]` signed: live bundler counters.
- `start_i` input 1: request a readout. Accepted only in IDLE.
- `abort_i` input 1: cancel an in-progress readout.
- `busy_o` output 1: high whenever state is not IDLE. Also used as the bundler hold.
- `data_o` output `ChunkCounters*CounterWidth`: current chunk.
- `valid_o` output 1: `data_o` valid.
- `ready_i` input 1: consumer accepts the beat.
- `idx_o` output `$clog2(NumChunks)`: chunk index of `data_o`.
- `last_o` output 1: `data_o` is chunk `NumChunks-1`.
- `done_o` output 1: one-cycle pulse when a readout completes.
- `clr_o` output 1: one-cycle bundler clear pulse.

## Operation
- States: IDLE, STREAM, DONE.
- IDLE:
  - On `start_i=1` with `abort_i=0`: load chunk 0 into the output register, set `idx=0`, and go to STREAM.
  - `abort_i` in IDLE is ignored but blocks `start_i` in the same cycle.
- STREAM:
  - `valid_o=1`.
  - On handshake (`valid_o & ready_i`) with `idx<NumChunks-1`: load chunk `idx+1` and increment `idx`.
  - On handshake with `idx==NumChunks-1`: go to DONE.
  - `data_o`, `idx_o` and `last_o` are stable while `valid_o & !ready_i`.
- DONE: lasts one cycle. `done_o=1` (and `clr_o=1` if configured), then return to IDLE.
- Abort: `abort_i=1` in STREAM returns the block to IDLE next cycle, with `valid_o=0`. No `done_o`, no `clr_o`. `abort_i` takes priority over a same-cycle handshake; that beat is not counted as delivered.
- Packing: `data_o[j*CounterWidth +: CounterWidth] = counter_i[idx*ChunkCounters + j]` for `j` in 0..`ChunkCounters-1`. Counters pass through unmodified as two's complement. There is no saturation or sign extension.
- Hold contract: `counter_i` is sampled at each chunk load, so upstream must keep counters frozen while `busy_o=1`. The block does not snapshot them.
- `start_i` in STREAM or DONE is ignored, not queued.
- `idx` never wraps past `NumChunks-1` inside STREAM. It returns to 0 only on a new start.

## Timing
- Reset values: state IDLE, `busy_o=0`, `valid_o=0`, `data_o=0`, `idx_o=0`, `last_o=0`, `done_o=0`, `clr_o=0`.
- Reset mid-stream drops every output to its reset value immediately (asynchronous). The partial readout is lost.
- Start latency: `start_i` sampled at edge t gives `valid_o=1` with chunk 0 after edge t; `busy_o` rises at the same time.
- Throughput: one beat per cycle with `ready_i` held high, no bubbles.
- With `ready_i` held high, a full readout takes `NumChunks` STREAM cycles plus 1 DONE cycle.
- `done_o` (and `clr_o`) are high in the cycle following the final handshake. The earliest accepted next `start_i` is the cycle after DONE.
- `last_o` is a registered function of `idx` and is valid whenever `valid_o=1`.

## Configuration
- `BUNDLER_READOUT_CLR_EN` defined:
  - `clr_o` pulses high for exactly the DONE cycle, coincident with `done_o`.
  - It is never asserted on abort or reset.
- `BUNDLER_READOUT_CLR_EN` undefined:
  - `clr_o` is tied to 0.
  - All other behaviour is identical, including DONE timing.

## Test plan
All scenarios use `HVDimension=16`, `CounterWidth=8`, `ChunkCounters=4`, so there are 4 chunks.
- Counters `counter[i]=i-8`, `ready_i=1`, pulse `start_i`:
  - Beats on 4 consecutive cycles, `idx_o` 0..3.
  - Beat 0 `data_o=0xFBFAF9F8`.
  - `last_o` only on beat 3.
  - `done_o` one cycle after beat 3.
  - `busy_o` low the cycle after that.
- Same stimulus with `ready_i` toggling 1,0,0,1,…:
  - `data_o`/`idx_o` stable during stalls.
  - Exactly 4 accepted beats in order, no duplicates or skips.
- `abort_i` on the cycle chunk 2 is valid and ready:
  - IDLE next cycle, `valid_o=0`.
  - `done_o=0`, `clr_o=0`.
  - A new `start_i` restarts at `idx_o=0`.
- Assert `rst_i` mid-stream at `idx=1`:
  - All outputs zero immediately.
  - After release, a `start_i` produces a full 4-beat readout.
- `start_i` held high through the whole readout: exactly one readout occurs, and a second begins only when `start_i` is seen in IDLE.
- `BUNDLER_READOUT_CLR_EN` defined: `clr_o` is a single-cycle pulse aligned with `done_o`. Undefined: `clr_o` stays 0 in all of the above.
